// File: rtl/alu.sv
// Registered single-cycle ALU: AND/OR/ADD/XOR/SUB/SLT/NOR with carry-out and zero flag.
// ADD and SUB share one WIDTH+1-bit adder; unknown opcodes produce zero.
module alu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_Sel,
    output logic [WIDTH-1:0] ALU_Out,
    output logic             coutfin,
    output logic             z
);

    typedef enum logic [3:0] {
        OpAnd = 4'b0000,
        OpOr  = 4'b0001,
        OpAdd = 4'b0010,
        OpXor = 4'b0011,
        OpSub = 4'b0110,
        OpSlt = 4'b0111,
        OpNor = 4'b1100
    } op_e;

    logic [WIDTH-1:0] alu_out_q, alu_out_d;
    logic             cout_q, cout_d;
    logic             z_q, z_d;

    logic             is_sub;
    logic [WIDTH-1:0] b_opnd;
    logic [WIDTH:0]   sum;
    logic             slt;

    // SUB reuses the adder as A + ~B + 1, so bit WIDTH is the no-borrow flag.
    assign is_sub = (ALU_Sel == OpSub);
    assign b_opnd = is_sub ? ~B : B;
    assign sum    = {1'b0, A} + {1'b0, b_opnd} + {{WIDTH{1'b0}}, is_sub};
    assign slt    = ($signed(A) < $signed(B));

    always_comb begin
        alu_out_d = '0;
        cout_d    = 1'b0;
        case (ALU_Sel)
            OpAnd: alu_out_d = A & B;
            OpOr:  alu_out_d = A | B;
            OpXor: alu_out_d = A ^ B;
            OpNor: alu_out_d = ~(A | B);
            OpSlt: alu_out_d = {{(WIDTH - 1){1'b0}}, slt};
            OpAdd, OpSub: begin
                alu_out_d = sum[WIDTH-1:0];
                cout_d    = sum[WIDTH];
            end
            default: begin
                alu_out_d = '0;
                cout_d    = 1'b0;
            end
        endcase
        z_d = (alu_out_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_out_q <= '0;
            cout_q    <= 1'b0;
            z_q       <= 1'b1;
        end else begin
            alu_out_q <= alu_out_d;
            cout_q    <= cout_d;
            z_q       <= z_d;
        end
    end

    assign ALU_Out = alu_out_q;
    assign coutfin = cout_q;
    assign z       = z_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for alu: expected results are queued when stimulus is driven and
// compared after the next rising edge.
module tb_alu;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a, b;
    logic [3:0]   sel;
    logic [W-1:0] alu_out;
    logic         coutfin, z;

    typedef struct {
        string        tag;
        logic [W-1:0] out;
        logic         cout;
        logic         z;
    } exp_t;

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (a),
        .B      (b),
        .ALU_Sel(sel),
        .ALU_Out(alu_out),
        .coutfin(coutfin),
        .z      (z)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input string tag, input logic r, input logic [3:0] s,
                                   input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t         e;
        logic [W:0]   wide;
        e.tag  = tag;
        e.out  = '0;
        e.cout = 1'b0;
        if (!r) begin
            case (s)
                4'b0000: e.out = x & y;
                4'b0001: e.out = x | y;
                4'b0010: begin
                    wide   = {1'b0, x} + {1'b0, y};
                    e.out  = wide[W-1:0];
                    e.cout = wide[W];
                end
                4'b0011: e.out = x ^ y;
                4'b0110: begin
                    e.out  = x - y;
                    e.cout = (x >= y);
                end
                4'b0111: e.out = ($signed(x) < $signed(y)) ? 1 : 0;
                4'b1100: e.out = ~(x | y);
                default: e.out = '0;
            endcase
        end
        e.z = (e.out == '0);
        return e;
    endfunction

    task automatic check_one();
        exp_t e;
        e = sb.pop_front();
        n_cmp++;
        assert (alu_out === e.out) else begin
            n_fail++;
            $error("FAIL %s ALU_Out got %h exp %h", e.tag, alu_out, e.out);
        end
        n_cmp++;
        assert (coutfin === e.cout) else begin
            n_fail++;
            $error("FAIL %s coutfin got %b exp %b", e.tag, coutfin, e.cout);
        end
        n_cmp++;
        assert (z === e.z) else begin
            n_fail++;
            $error("FAIL %s z got %b exp %b", e.tag, z, e.z);
        end
    endtask

    // Drive on the falling edge, wiggle inputs afterwards to show only the edge value counts.
    task automatic step(input string tag, input logic r, input logic [3:0] s,
                        input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        rst = r;
        sel = s;
        a   = x;
        b   = y;
        sb.push_back(model(tag, r, s, x, y));
        @(posedge clk);
        #1;
        sel = 4'b0010;
        a   = 32'hDEAD_BEEF;
        b   = 32'h1234_5678;
        check_one();
    endtask

    initial begin
        rst = 1'b1;
        sel = 4'b0010;
        a   = 32'h1;
        b   = 32'h1;
        step("reset0", 1'b1, 4'b0010, 32'h5, 32'h6);
        step("reset1", 1'b1, 4'b0001, 32'hFFFF_FFFF, 32'h0);

        step("and_1_2", 1'b0, 4'b0000, 32'h1, 32'h2);
        step("or_1_2",  1'b0, 4'b0001, 32'h1, 32'h2);
        step("add_1_2", 1'b0, 4'b0010, 32'h1, 32'h2);
        step("add_3_4", 1'b0, 4'b0010, 32'h3, 32'h4);
        step("undef_f", 1'b0, 4'b1111, 32'h3, 32'h4);
        step("undef_4", 1'b0, 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step("add_wrap", 1'b0, 4'b0010, 32'hFFFF_FFFF, 32'h1);
        step("sub_3_4", 1'b0, 4'b0110, 32'h3, 32'h4);
        step("sub_4_4", 1'b0, 4'b0110, 32'h4, 32'h4);
        step("sub_9_2", 1'b0, 4'b0110, 32'h9, 32'h2);
        step("add_sovf", 1'b0, 4'b0010, 32'h7FFF_FFFF, 32'h1);
        step("slt_m1_1", 1'b0, 4'b0111, 32'hFFFF_FFFF, 32'h1);
        step("slt_1_m1", 1'b0, 4'b0111, 32'h1, 32'hFFFF_FFFF);
        step("slt_eq",  1'b0, 4'b0111, 32'h5, 32'h5);
        step("nor_f0",  1'b0, 4'b1100, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        step("xor_f0",  1'b0, 4'b0011, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
        step("nor_0",   1'b0, 4'b1100, 32'h0, 32'h0);
        step("xor_eq",  1'b0, 4'b0011, 32'hA5A5_A5A5, 32'hA5A5_A5A5);

        step("b2b_add0", 1'b0, 4'b0010, 32'h10, 32'h20);
        step("b2b_rst",  1'b1, 4'b0010, 32'h11, 32'h22);
        step("b2b_add1", 1'b0, 4'b0010, 32'h12, 32'h24);
        step("b2b_add2", 1'b0, 4'b0010, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 12; i++) begin
            logic [3:0]  rs;
            logic [W-1:0] ra, rb;
            rs = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = (i % 3 == 0) ? ra : $urandom;
            step("rand", 1'b0, rs, ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter: WIDTH, default 32, data path width in bits for A, B and ALU_Out.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 A  input  WIDTH  operand A.
REQ-005 B  input  WIDTH  operand B.
REQ-006 ALU_Sel  input  4  operation select.
REQ-007 ALU_Out  output  WIDTH  registered result.
REQ-008 coutfin  output  1  registered carry-out of the adder path.
REQ-009 z  output  1  registered zero flag; high when ALU_Out is all zeros.

Function
REQ-010 The block SHALL sample A, B and ALU_Sel on each rising clk edge and present the result on ALU_Out, coutfin and z one cycle later; outputs SHALL be held stable between edges.
REQ-011 The block SHALL decode ALU_Sel as follows:
- 0000 AND: A & B.
- 0001 OR: A | B.
- 0010 ADD: A + B.
- 0011 XOR: A ^ B.
- 0110 SUB: A - B, computed in two's complement as A + ~B + 1.
- 0111 SLT: 1 if A < B as signed values, else 0, zero-extended to WIDTH.
- 1100 NOR: ~(A | B).
REQ-012 Any other ALU_Sel code SHALL produce ALU_Out = 0 and coutfin = 0.
REQ-013 ADD and SUB SHALL share one WIDTH+1-bit two's-complement adder.
- The result SHALL be the low WIDTH bits, wrapping modulo 2^WIDTH.
- coutfin SHALL be bit WIDTH of the sum.
- For SUB, coutfin = 1 means no borrow (A >= B unsigned).
REQ-014 For AND, OR, XOR, SLT and NOR, coutfin SHALL be 0.
REQ-015 z SHALL be registered in the same cycle as ALU_Out and SHALL equal (next ALU_Out == 0), covering all opcodes, including undefined codes and wrap-around results.
REQ-016 Operand or select changes between edges SHALL have no effect until the next rising edge; there is no handshake, and a new operation is accepted every cycle.
REQ-017 No signed-overflow flag is produced; signed overflow SHALL wrap silently.

Reset
REQ-018 While rst is high at a rising edge, the block SHALL set ALU_Out = 0, coutfin = 0 and z = 1, regardless of A, B and ALU_Sel.
REQ-019 Reset asserted mid-stream SHALL discard the in-flight operation.
REQ-020 The first operation after rst deasserts SHALL appear on the outputs one cycle after the first non-reset edge.

Verification
REQ-021 Ops with A=1, B=2:
- AND -> ALU_Out=0, z=1, coutfin=0.
- OR -> 3, z=0.
- ADD -> 3, coutfin=0.
REQ-022 ADD with A=3, B=4 -> ALU_Out=7, z=0, coutfin=0; applying ALU_Sel=1111 on the next cycle -> ALU_Out=0, z=1, coutfin=0.
REQ-023 Adder boundaries:
- ADD A=FFFFFFFF, B=1 -> ALU_Out=0, coutfin=1, z=1.
- SUB A=3, B=4 -> FFFFFFFF, coutfin=0.
- SUB A=4, B=4 -> 0, coutfin=1, z=1.
REQ-024 SLT:
- A=FFFFFFFF, B=1 -> ALU_Out=1.
- A=1, B=FFFFFFFF -> 0.
REQ-025 Logic ops with A=F0F0F0F0, B=0F0F0F0F:
- NOR -> 0.
- XOR -> FFFFFFFF.
REQ-026 Assert rst for one edge during back-to-back ADDs -> outputs 0/0/z=1 for that cycle, then correct results resume one cycle after deassertion.
